// File: rtl/tinyalu_pkg.sv
// Shared types for the tinyalu datapath and its instruction issue queue.
package tinyalu_pkg;

  // Instruction word width; the issue queue treats the word as opaque.
  localparam int INSTR_W = 8;

  typedef logic [INSTR_W-1:0] instruction_t;

  // Encoding presented to the datapath whenever nothing is issued.
  localparam instruction_t INSTR_NOP = '0;

  // Issue state machine: IDLE (nothing issued), ARM (first issued cycle,
  // done masked), WAIT (waiting for done or watchdog expiry).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2
  } iq_state_t;

endpackage : tinyalu_pkg

// File: rtl/iq_fifo.sv
// Circular FIFO holding queued (not yet issued) instructions.
// Pointers wrap naturally; occupancy is tracked in a separate counter so
// full and empty are simple decodes. Flush empties the queue and wins over
// any push or pop presented in the same cycle.
module iq_fifo
  import tinyalu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  instruction_t                   din,
  input  logic                           pop,
  input  logic                           flush,
  output instruction_t                   head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  instruction_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  // A push into a full queue is refused even if a pop frees a slot this cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  // Storage write; contents need no reset because occupancy gates all reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : iq_fifo

// File: rtl/instr_issue_queue.sv
// Instruction issue queue in front of the ALU/memory/instruction-unit
// datapath. Buffers producer instructions, presents one at a time on instr
// until done retires it, and drops an instruction whose done never arrives
// within TIMEOUT cycles (flagging timeout_err).
module instr_issue_queue
  import tinyalu_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  instruction_t                   in_instr,
  output logic                           in_ready,
  input  logic                           flush,
  output instruction_t                   instr,
  output logic                           instr_valid,
  input  logic                           done,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic [15:0]                    retired,
  output logic                           timeout_err
);

  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  iq_state_t       state_q, state_d;
  instruction_t    instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [15:0]     retired_q, retired_d;
  logic            terr_q, terr_d;

  logic            fifo_full;
  logic            fifo_empty;
  instruction_t    fifo_head;
  logic            can_pop;
  logic            pop;

  // A flush cycle suppresses the pop, so nothing new issues during it.
  assign can_pop = !fifo_empty && !flush;

  iq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .din   (in_instr),
    .pop   (pop),
    .flush (flush),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign in_ready    = !fifo_full;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign retired     = retired_q;
  assign timeout_err = terr_q;

  // Issue FSM, watchdog and retirement bookkeeping.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    wd_d      = wd_q;
    retired_d = retired_q;
    terr_d    = terr_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          instr_d = fifo_head;
          valid_d = 1'b1;
          wd_d    = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        // done is deliberately ignored here: it may still be high from the
        // instruction that just retired.
        wd_d    = wd_q + 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        if (done) begin
          retired_d = retired_q + 16'd1;
          if (can_pop) begin
            // Back-to-back issue with no NOP bubble.
            pop     = 1'b1;
            instr_d = fifo_head;
            valid_d = 1'b1;
            wd_d    = '0;
            state_d = ARM;
          end else begin
            instr_d = INSTR_NOP;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else if (wd_q == WD_LAST) begin
          // Watchdog expiry: drop the instruction without retiring it.
          terr_d  = 1'b1;
          instr_d = INSTR_NOP;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        instr_d = INSTR_NOP;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, issue register and counters; reset returns everything to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      instr_q   <= INSTR_NOP;
      valid_q   <= 1'b0;
      wd_q      <= '0;
      retired_q <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      wd_q      <= wd_d;
      retired_q <= retired_d;
      terr_q    <= terr_d;
    end
  end

endmodule : instr_issue_queue

// File: tb/tb_instr_issue_queue.sv
// Directed testbench for instr_issue_queue (DEPTH=8, TIMEOUT=16).
module tb_instr_issue_queue;
  import tinyalu_pkg::*;

  logic          clk;
  logic          reset;
  logic          in_valid;
  instruction_t  in_instr;
  logic          in_ready;
  logic          flush;
  instruction_t  instr;
  logic          instr_valid;
  logic          done;
  logic [3:0]    count;
  logic [15:0]   retired;
  logic          timeout_err;

  int nvec  = 0;
  int nfail = 0;

  instr_issue_queue #(
    .DEPTH   (8),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .done        (done),
    .count       (count),
    .retired     (retired),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, reports it on one line.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    if (obs === exp) $display("[%0t] %s ok (%0h)", $time, tag, obs);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_instr = '0;
    flush    = 1'b0;
    done     = 1'b0;
    reset    = 1'b1;
    #3;
    reset    = 1'b0;
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_in_ready"},    32'(in_ready),    32'd1);
    chk({pfx, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({pfx, "_instr"},       32'(instr),       32'(INSTR_NOP));
    chk({pfx, "_count"},       32'(count),       32'd0);
    chk({pfx, "_retired"},     32'(retired),     32'd0);
    chk({pfx, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  logic [7:0] exp_seq [5];
  logic       exp_vld [5];

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    chk_reset_values("rst");

    // ---------------- single push, 2-cycle latency ----------------
    in_valid = 1'b1; in_instr = 8'h15;
    step();                                   // push accepted
    in_valid = 1'b0;
    chk("s1_count_after_push", 32'(count), 32'd1);
    chk("s1_valid_after_push", 32'(instr_valid), 32'd0);
    step();                                   // issued
    chk("s1_instr", 32'(instr), 32'h15);
    chk("s1_valid", 32'(instr_valid), 32'd1);
    chk("s1_count_issued", 32'(count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s1_hold_instr", 32'(instr), 32'h15);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    chk("s1_retired", 32'(retired), 32'd1);
    chk("s1_instr_nop", 32'(instr), 32'(INSTR_NOP));
    chk("s1_valid_low", 32'(instr_valid), 32'd0);

    // ---------------- fill to full, no done ----------------
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1; in_instr = 8'(i);
      step();
      if (i == 8) begin
        chk("s2_count_peak7", 32'(count), 32'd7);
        chk("s2_head_issued", 32'(instr), 32'h01);
      end
    end
    chk("s2_count_full", 32'(count), 32'd8);
    chk("s2_in_ready_full", 32'(in_ready), 32'd0);
    in_instr = 8'h0A;
    step();                                   // refused push
    in_valid = 1'b0;
    chk("s2_count_refused", 32'(count), 32'd8);
    chk("s2_instr_still_01", 32'(instr), 32'h01);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("s2_next_instr_02", 32'(instr), 32'h02);
    chk("s2_count_after_pop", 32'(count), 32'd7);
    chk("s2_retired", 32'(retired), 32'd1);

    // ---------------- back-to-back with done held high ----------------
    do_reset();
    done = 1'b1;
    in_valid = 1'b1; in_instr = 8'hA1;
    step();
    in_instr = 8'hA2;
    step();
    chk("s3_instr_a1_arm", 32'(instr), 32'hA1);
    in_instr = 8'hA3;
    step();
    chk("s3_instr_a1_wait", 32'(instr), 32'hA1);
    in_valid = 1'b0;
    exp_seq = '{8'hA2, 8'hA2, 8'hA3, 8'hA3, 8'h00};
    exp_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s3_instr_seq", 32'(instr), 32'(exp_seq[i]));
      chk("s3_valid_seq", 32'(instr_valid), 32'(exp_vld[i]));
    end
    done = 1'b0;
    chk("s3_retired", 32'(retired), 32'd3);

    // ---------------- watchdog timeout ----------------
    do_reset();
    in_valid = 1'b1; in_instr = 8'h33;
    step();
    in_valid = 1'b0;
    step();                                   // instr_valid rises here
    chk("s4_issued", 32'(instr), 32'h33);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("s4_still_valid", 32'(instr_valid), 32'd1);
    end
    chk("s4_no_err_yet", 32'(timeout_err), 32'd0);
    step();                                   // 16 cycles after rise
    chk("s4_valid_fell", 32'(instr_valid), 32'd0);
    chk("s4_timeout_err", 32'(timeout_err), 32'd1);
    chk("s4_retired_zero", 32'(retired), 32'd0);
    chk("s4_instr_nop", 32'(instr), 32'(INSTR_NOP));
    in_valid = 1'b1; in_instr = 8'h34;
    step();
    in_valid = 1'b0;
    step();
    chk("s4_issue_34", 32'(instr), 32'h34);
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("s4_retired_34", 32'(retired), 32'd1);
    chk("s4_err_sticky", 32'(timeout_err), 32'd1);

    // ---------------- flush while first word in WAIT ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = 8'(8'hB1 + i);
      step();
    end
    in_valid = 1'b0;
    chk("s5_count_pre_flush", 32'(count), 32'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("s5_count_flushed", 32'(count), 32'd0);
    chk("s5_instr_kept", 32'(instr), 32'hB1);
    chk("s5_valid_kept", 32'(instr_valid), 32'd1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("s5_retired", 32'(retired), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s5_nothing_issued", 32'(instr_valid), 32'd0);
    end

    // ---------------- async reset mid-WAIT ----------------
    do_reset();
    in_valid = 1'b1; in_instr = 8'hC1;
    step();
    in_instr = 8'hC2;
    step();
    in_valid = 1'b0;
    step();                                   // in WAIT, C2 queued
    chk("s6_valid_before", 32'(instr_valid), 32'd1);
    chk("s6_count_before", 32'(count), 32'd1);
    #1;
    reset = 1'b1;
    #1;                                       // well before next edge
    chk_reset_values("s6");
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule : tb_instr_issue_queue
